ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Multi-cycle instruction fetch stage that replaces direct combinational instruction lookup.
- Issues one AXI4-Lite-style read per instruction, holds the fetched word plus its PC toward the decode stage under a valid/ready handshake, then waits for the writeback stage's next-PC (dnpc) before fetching again.
- Sits between the PC/writeback path (upstream redirect) and the decode stage (downstream consumer).
- One outstanding fetch at a time; sticky error reporting.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
TIMEOUT, 255, max cycles in WAIT before bus timeout error (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
arvalid  out  1  read address valid
araddr  out  32  read address (= current PC)
arready  in  1  read address accepted
rvalid  in  1  read data valid
rdata  in  32  read data (instruction)
rresp  in  2  read response, 2'b00 = OKAY
rready  out  1  read data ready
out_valid  out  1  instruction valid to decode
out_inst  out  32  fetched instruction
out_pc  out  32  PC of out_inst
out_ready  in  1  decode accepts instruction
wb_valid  in  1  writeback commit strobe
wb_dnpc  in  32  next PC from writeback
fetch_err  out  1  sticky error flag
err_cause  out  2  0 none, 1 bus resp, 2 misaligned dnpc, 3 timeout
fetch_cnt  out  32  completed fetches, wraps at 2^32

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, arvalid=rready=out_valid=0, out_inst=0, out_pc=RESET_PC, fetch_err=0, err_cause=0, fetch_cnt=0, timeout counter=0.
- IDLE: one cycle after reset release, then go to REQ.
- REQ:
  - arvalid=1, araddr=pc.
  - Both held stable until arready is seen; handshake completes in the same cycle arvalid&arready.
  - Then go to WAIT.
  - rvalid in REQ is ignored.
- WAIT:
  - rready=1; timeout counter increments each cycle.
  - On rvalid with rresp==0: latch out_inst<=rdata, out_pc<=pc, fetch_cnt+=1, then go to HOLD.
  - On rvalid with rresp!=0: go to ERR, err_cause=1.
  - If the counter reaches TIMEOUT with no rvalid: go to ERR, err_cause=3.
  - The counter clears on leaving WAIT.
- HOLD:
  - out_valid=1; out_inst and out_pc held stable.
  - On out_ready: go to WB_WAIT and drop out_valid the next cycle.
  - Minimum fetch-to-decode latency is 1 cycle after rvalid.
- WB_WAIT:
  - On wb_valid: if wb_dnpc[1:0]!=0, go to ERR with err_cause=2; else pc<=wb_dnpc and go to REQ.
  - wb_valid in any other state is ignored; no queuing.
- ERR: terminal state; all valid/ready outputs 0, fetch_err=1, err_cause frozen. Only reset exits.
- Simultaneous events:
  - rvalid in the same cycle WAIT times out: the data wins.
  - out_ready with out_valid=0 has no effect.
- Reset mid-transaction abandons the outstanding read. The slave is also reset, so no response draining is required.
- Best-case loop (zero-wait bus, decode always ready, immediate wb) is REQ→WAIT→HOLD→WB_WAIT = 4 cycles per instruction.

Decomposition:
- Shared package:
  - state enum (IDLE, REQ, WAIT, HOLD, WB_WAIT, ERR)
  - err_cause encodings
  - RESP_OKAY constant
  - RESET_PC default
- Sub-module fetch_timeout_ctr: loadable counter with clear/enable and a terminal-count flag, parameterised by TIMEOUT. Reused later by the LSU.

Test Plan:
- Reset release, arready=1, rvalid one cycle later with rdata=0x00000413 -> araddr=0x80000000 on the first arvalid; out_valid with out_inst=0x00000413, out_pc=0x80000000; fetch_cnt=1.
- arready held low 3 cycles -> arvalid and araddr=0x80000000 stable all 3 cycles; exactly one handshake.
- out_ready low 5 cycles in HOLD -> out_valid, out_inst and out_pc stable; no new arvalid until wb_valid with wb_dnpc=0x80000004; next araddr=0x80000004.
- wb_dnpc=0x80000006 -> ERR; fetch_err=1, err_cause=2; no further arvalid until rst pulse.
- rvalid with rresp=2'b10 -> fetch_err=1, err_cause=1; out_valid never asserted; fetch_cnt unchanged.
- TIMEOUT=8, rvalid never asserted -> ERR exactly 8 cycles after entering WAIT, err_cause=3. Async rst asserted mid-WAIT -> outputs reset immediately, without a clock edge.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared state, error-cause and bus-response definitions for the instruction fetch controller.
package ifu_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_WB_WAIT,
    ST_ERR
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_BUS      = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } err_cause_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable up-counter with clear/enable; tc flags the last permitted enabled cycle.
// Latency: cnt updates one edge after clr/load/en; tc is combinational from cnt and en.
// Backpressure: none, the owner decides when to enable and clear.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Asserted during the TIMEOUT-th enabled cycle, so the owner leaves on that edge.
  assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch: one read per PC, instruction held to decode, then waits for next PC.
// Latency: out_valid one cycle after the accepted rvalid; best case four cycles per instruction.
// Backpressure: holds arvalid until arready and out_valid until out_ready; one fetch outstanding.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        wb_valid,
  input  logic [31:0] wb_dnpc,
  output logic        fetch_err,
  output logic [1:0]  err_cause,
  output logic [31:0] fetch_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         in_wait;
  logic         wait_exit;
  logic         to_tc;

  assign araddr    = pc;
  assign in_wait   = (state == ST_WAIT);
  assign wait_exit = in_wait && (rvalid || to_tc);

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (wait_exit),
    .en       (in_wait),
    .load     (1'b0),
    .load_val ('0),
    .tc       (to_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= RESET_PC;
      fetch_err <= 1'b0;
      err_cause <= CAUSE_NONE;
      fetch_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_REQ;
          arvalid <= 1'b1;
        end
        ST_REQ: begin
          if (arready) begin
            state   <= ST_WAIT;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Data arriving on the timeout cycle still counts as a good fetch.
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp == RESP_OKAY) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              out_inst  <= rdata;
              out_pc    <= pc;
              fetch_cnt <= fetch_cnt + 32'd1;
            end else begin
              state     <= ST_ERR;
              fetch_err <= 1'b1;
              err_cause <= CAUSE_BUS;
            end
          end else if (to_tc) begin
            rready    <= 1'b0;
            state     <= ST_ERR;
            fetch_err <= 1'b1;
            err_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_WB_WAIT;
            out_valid <= 1'b0;
          end
        end
        ST_WB_WAIT: begin
          if (wb_valid) begin
            if (pc_aligned(wb_dnpc[1:0])) begin
              pc      <= wb_dnpc;
              state   <= ST_REQ;
              arvalid <= 1'b1;
            end else begin
              state     <= ST_ERR;
              fetch_err <= 1'b1;
              err_cause <= CAUSE_MISALIGN;
            end
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state     <= ST_ERR;
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          out_valid <= 1'b0;
          fetch_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios plus a randomized stream against a PC/count model.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TO     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_dnpc = '0;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .arready   (arready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rready    (rready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .wb_valid  (wb_valid),
    .wb_dnpc   (wb_dnpc),
    .fetch_err (fetch_err),
    .err_cause (err_cause),
    .fetch_cnt (fetch_cnt)
  );

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_dnpc = '0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic wait_ar(output bit ok);
    for (int i = 0; i < 20 && !arvalid; i++) cyc();
    ok = arvalid;
  endtask

  task automatic reach_wait(output bit ok);
    wait_ar(ok);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] inst, output bit ok);
    reach_wait(ok);
    rvalid = 1'b1; rdata = inst; rresp = 2'b00;
    cyc();
    rvalid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'hdead_beef; rresp = 2'b11;
    out_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'h0000_0006;
    cyc();
    cyc();
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", rready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    n_checks++; if (out_pc !== RST_PC) begin n_fail++; $display("FAIL reset_out_pc: got %h want %h", out_pc, RST_PC); end
    n_checks++; if (araddr !== RST_PC) begin n_fail++; $display("FAIL reset_araddr: got %h want %h", araddr, RST_PC); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
    n_checks++; if (err_cause !== 2'd0) begin n_fail++; $display("FAIL reset_err_cause: got %0d want 0", err_cause); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_fetch_cnt: got %0d want 0", fetch_cnt); end
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; out_ready = 1'b0; wb_valid = 1'b0;
    rst = 1'b1;
    cyc();
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL reset_idle_one_cycle: arvalid got %b want 1", arvalid); end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    wait_ar(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_ar_timeout: arvalid got %b want 1", ok); end
    n_checks++; if (araddr !== RST_PC) begin n_fail++; $display("FAIL basic_araddr: got %h want %h", araddr, RST_PC); end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    n_checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL basic_wait: rready=%b arvalid=%b want 1 0", rready, arvalid); end
    rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
    cyc();
    rvalid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    n_checks++; if (out_inst !== 32'h0000_0413) begin n_fail++; $display("FAIL basic_out_inst: got %h want 00000413", out_inst); end
    n_checks++; if (out_pc !== RST_PC) begin n_fail++; $display("FAIL basic_out_pc: got %h want %h", out_pc, RST_PC); end
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_fetch_cnt: got %0d want 1", fetch_cnt); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL basic_rready_drop: got %b want 0", rready); end
  endtask

  task automatic test_stall();
    bit ok;
    int hs;
    do_reset();
    wait_ar(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_ar_timeout: arvalid got %b want 1", ok); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== RST_PC) begin
        n_fail++; $display("FAIL stall_ar_stable: arvalid=%b araddr=%h want 1 %h", arvalid, araddr, RST_PC);
      end
    end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    hs = 1;
    for (int i = 0; i < 3; i++) begin
      if (arvalid) hs++;
      cyc();
    end
    rvalid = 1'b1; rdata = 32'h0000_0013; rresp = 2'b00;
    cyc();
    rvalid = 1'b0;
    n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL stall_one_handshake: got %0d want 1", hs); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || out_pc !== RST_PC) begin
        n_fail++; $display("FAIL stall_hold_stable: v=%b inst=%h pc=%h want 1 00000013 %h", out_valid, out_inst, out_pc, RST_PC);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid_drop: got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL stall_no_ar_before_wb: got %b want 0", arvalid); end
    end
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0004;
    cyc();
    wb_valid = 1'b0;
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_next_ar: arvalid=%b araddr=%h want 1 80000004", arvalid, araddr); end
  endtask

  task automatic test_misalign();
    bit ok;
    int bad;
    do_reset();
    fetch_one(32'h0000_0013, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL misalign_ar_timeout: arvalid got %b want 1", ok); end
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0006;
    cyc();
    n_checks++; if (fetch_err !== 1'b1 || err_cause !== 2'd2) begin n_fail++; $display("FAIL misalign_err: fetch_err=%b cause=%0d want 1 2", fetch_err, err_cause); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      arready = 1'b1; rvalid = 1'($urandom_range(0, 1)); out_ready = 1'b1;
      wb_valid = 1'b1; wb_dnpc = 32'h8000_0008;
      cyc();
      if (arvalid || rready || out_valid || !fetch_err || err_cause != 2'd2) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL misalign_terminal: %0d bad cycles want 0", bad); end
    do_reset();
    n_checks++; if (fetch_err !== 1'b0 || err_cause !== 2'd0) begin n_fail++; $display("FAIL misalign_reset_clear: fetch_err=%b cause=%0d want 0 0", fetch_err, err_cause); end
    wait_ar(ok);
    n_checks++; if (ok !== 1'b1 || araddr !== RST_PC) begin n_fail++; $display("FAIL misalign_restart: arvalid=%b araddr=%h want 1 %h", ok, araddr, RST_PC); end
  endtask

  task automatic test_bus_err();
    bit ok;
    int seen;
    do_reset();
    fetch_one(32'h0000_0093, ok);
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0010;
    cyc();
    wb_valid = 1'b0;
    reach_wait(ok);
    n_checks++; if (ok !== 1'b1 || fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL buserr_setup: ok=%b cnt=%0d want 1 1", ok, fetch_cnt); end
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'h1234_5678;
    cyc();
    rvalid = 1'b0; rresp = 2'b00;
    n_checks++; if (fetch_err !== 1'b1 || err_cause !== 2'd1) begin n_fail++; $display("FAIL buserr_err: fetch_err=%b cause=%0d want 1 1", fetch_err, err_cause); end
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL buserr_cnt: got %0d want 1", fetch_cnt); end
    seen = out_valid ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cyc();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL buserr_no_out_valid: %0d cycles valid want 0", seen); end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    do_reset();
    reach_wait(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timeout_ar: arvalid got %b want 1", ok); end
    k = 0;
    while (!fetch_err && k < 3 * TO) begin
      cyc();
      k++;
    end
    n_checks++; if (k !== TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", k, TO); end
    n_checks++; if (err_cause !== 2'd3) begin n_fail++; $display("FAIL timeout_cause: got %0d want 3", err_cause); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL timeout_rready: got %b want 0", rready); end
  endtask

  task automatic test_timeout_race();
    bit ok;
    do_reset();
    reach_wait(ok);
    repeat (TO - 1) cyc();
    rvalid = 1'b1; rdata = 32'h0000_0099; rresp = 2'b00;
    cyc();
    rvalid = 1'b0;
    n_checks++; if (ok !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL race_no_err: ok=%b fetch_err=%b want 1 0", ok, fetch_err); end
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0000_0099) begin n_fail++; $display("FAIL race_data_wins: v=%b inst=%h want 1 00000099", out_valid, out_inst); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    fetch_one(32'h1234_5677, ok);
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0020;
    cyc();
    wb_valid = 1'b0;
    reach_wait(ok);
    repeat (3) cyc();
    n_checks++; if (rready !== 1'b1 || fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL async_setup: rready=%b cnt=%0d want 1 1", rready, fetch_cnt); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (rready !== 1'b0 || arvalid !== 1'b0) begin n_fail++; $display("FAIL async_handshake: rready=%b arvalid=%b want 0 0", rready, arvalid); end
    n_checks++; if (fetch_cnt !== 32'd0 || out_inst !== 32'h0) begin n_fail++; $display("FAIL async_state: cnt=%0d inst=%h want 0 0", fetch_cnt, out_inst); end
    n_checks++; if (araddr !== RST_PC || out_pc !== RST_PC) begin n_fail++; $display("FAIL async_pc: araddr=%h out_pc=%h want %h", araddr, out_pc, RST_PC); end
  endtask

  task automatic test_random_stream();
    bit ok;
    logic [31:0] exp_pc, inst, tmp, dnpc;
    int exp_cnt, ar_d, r_d, rd_d, wb_d;
    do_reset();
    exp_pc = RST_PC;
    exp_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, TO - 2);
      rd_d = $urandom_range(0, 3); wb_d = $urandom_range(0, 3);
      inst = $urandom; tmp = $urandom; dnpc = {tmp[31:2], 2'b00};
      wait_ar(ok);
      n_checks++; if (ok !== 1'b1 || araddr !== exp_pc) begin n_fail++; $display("FAIL rnd_araddr[%0d]: arvalid=%b araddr=%h want 1 %h", n, ok, araddr, exp_pc); end
      for (int i = 0; i < ar_d; i++) begin
        rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;
        cyc();
        n_checks++; if (arvalid !== 1'b1 || araddr !== exp_pc) begin n_fail++; $display("FAIL rnd_ar_stable[%0d]: arvalid=%b araddr=%h", n, arvalid, araddr); end
      end
      rvalid = 1'b0; arready = 1'b1;
      cyc();
      arready = 1'b0;
      for (int i = 0; i < r_d; i++) cyc();
      n_checks++; if (out_valid !== 1'b0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL rnd_wait[%0d]: out_valid=%b fetch_err=%b want 0 0", n, out_valid, fetch_err); end
      rvalid = 1'b1; rdata = inst; rresp = 2'b00;
      cyc();
      rvalid = 1'b0;
      exp_cnt++;
      for (int i = 0; i <= rd_d; i++) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== inst || out_pc !== exp_pc || fetch_cnt !== 32'(exp_cnt) || arvalid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_hold[%0d]: v=%b inst=%h pc=%h cnt=%0d want 1 %h %h %0d", n, out_valid, out_inst, out_pc, fetch_cnt, inst, exp_pc, exp_cnt);
        end
        wb_valid = 1'($urandom_range(0, 1)); wb_dnpc = 32'h0000_0003;
        if (i < rd_d) cyc();
      end
      wb_valid = 1'b0; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      for (int i = 0; i < wb_d; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        cyc();
        n_checks++; if (arvalid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_wb_wait[%0d]: arvalid=%b out_valid=%b want 0 0", n, arvalid, out_valid); end
      end
      out_ready = 1'b0; wb_valid = 1'b1; wb_dnpc = dnpc;
      cyc();
      wb_valid = 1'b0;
      exp_pc = dnpc;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0;
    int nav, bad;
    do_reset();
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; rdata = 32'h0010_0093;
    out_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'h8000_0100;
    repeat (8) cyc();
    c0 = fetch_cnt;
    nav = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (arvalid) begin
        nav++;
        if (araddr !== 32'h8000_0100) bad++;
      end
    end
    n_checks++; if (nav !== 10) begin n_fail++; $display("FAIL b2b_ar_count: got %0d want 10", nav); end
    n_checks++; if (fetch_cnt - c0 !== 32'd10) begin n_fail++; $display("FAIL b2b_fetch_rate: got %0d want 10", fetch_cnt - c0); end
    n_checks++; if (bad !== 0 || out_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL b2b_data: bad_addr=%0d inst=%h want 0 00100093", bad, out_inst); end
    arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_misalign();
    test_bus_err();
    test_timeout();
    test_timeout_race();
    test_async_reset();
    test_random_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
